// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the RV32I pipeline (master) and hazard_ctrl (slave).
// Carries the stage-register observations in and the stage hold/flush controls out.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        br_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_keep;
    logic        if_keep;
    logic        if_flush;
    logic        id_keep;
    logic        id_nop;
    logic [1:0]  id_ex_write;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
               wb_rd, wb_regwrite, br_taken, dmem_req, dmem_ready,
        input  pc_keep, if_keep, if_flush, id_keep, id_nop, id_ex_write,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
               wb_rd, wb_regwrite, br_taken, dmem_req, dmem_ready,
        output pc_keep, if_keep, if_flush, id_keep, id_nop, id_ex_write,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: load-use bubble, multi-cycle branch flush, dmem freeze.
// Mealy outputs, zero latency; optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_DEPTH - 1);

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       br_pend_q, br_pend_d;

    logic lu;
    logic mem_stall;
    logic br_eff;

    assign lu = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                ((hz.id_uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                 (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));
    assign mem_stall = hz.dmem_req && !hz.dmem_ready;
    // A branch latched during a freeze is replayed as if it resolved now.
    assign br_eff    = hz.br_taken || br_pend_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            ret_q     <= ST_RUN;
            fcnt_q    <= 2'd0;
            br_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            fcnt_q    <= fcnt_d;
            br_pend_q <= br_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        fcnt_d    = fcnt_q;
        br_pend_d = br_pend_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    ret_d   = ST_RUN;
                end else if (br_eff) begin
                    br_pend_d = 1'b0;
                    fcnt_d    = FCNT_INIT;
                    state_d   = (FCNT_INIT != 2'd0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    ret_d   = ST_FLUSH;
                end else if (fcnt_q <= 2'd1) begin
                    fcnt_d  = 2'd0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = 2'(fcnt_q - 2'd1);
                end
            end
            ST_MEM_WAIT: begin
                br_pend_d = br_pend_q || hz.br_taken;
                if (hz.dmem_ready) begin
                    // A pending branch supersedes any interrupted flush and restarts it from RUN.
                    if (br_pend_q || hz.br_taken) begin
                        state_d = ST_RUN;
                        fcnt_d  = 2'd0;
                    end else begin
                        state_d = ret_q;
                    end
                    ret_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        hz.pc_keep  = 1'b0;
        hz.if_keep  = 1'b0;
        hz.if_flush = 1'b0;
        hz.id_keep  = 1'b0;
        hz.id_nop   = 1'b0;
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        hz.pc_keep = 1'b1;
                        hz.if_keep = 1'b1;
                        hz.id_keep = 1'b1;
                    end else if (br_eff) begin
                        hz.if_flush = 1'b1;
                        hz.id_nop   = 1'b1;
                    end else if (lu) begin
                        hz.pc_keep = 1'b1;
                        hz.if_keep = 1'b1;
                        hz.id_nop  = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (mem_stall) begin
                        hz.pc_keep = 1'b1;
                        hz.if_keep = 1'b1;
                        hz.id_keep = 1'b1;
                    end else begin
                        hz.if_flush = 1'b1;
                        hz.id_nop   = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!hz.dmem_ready) begin
                        hz.pc_keep = 1'b1;
                        hz.if_keep = 1'b1;
                        hz.id_keep = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bypass stays live during the freeze so held operands catch a late write-back.
    always_comb begin
        hz.id_ex_write = 2'b00;
        if (rst && hz.wb_regwrite && (hz.wb_rd != 5'd0)) begin
            hz.id_ex_write[1] = (hz.wb_rd == hz.id_rs1);
            hz.id_ex_write[0] = (hz.wb_rd == hz.id_rs2);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_events_q;
    logic        br_accept;

    assign br_accept = (state_q == ST_RUN) && !mem_stall && br_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 16'd0;
        end else begin
            if (hz.pc_keep && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (br_accept && (flush_events_q != 16'hFFFF)) begin
                flush_events_q <= flush_events_q + 16'd1;
            end
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_events = 16'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It drives the decode stage's `keep` and `nop` inputs, the PC/IF hold and flush, and the `ID_EX_write` write-back bypass selects. It resolves three hazard classes:
- load-use data hazards, with a one-bubble stall;
- taken branches and jumps, with a multi-cycle flush;
- data-memory wait states, with a full freeze.

It sits beside the ID stage and observes the EX, MEM and WB pipeline registers.

## Interface
Reset is `rst`, asynchronous, active-low; the clock is `clk`.

Parameters:
- `FLUSH_DEPTH`, default 2: number of bubble cycles injected after a taken branch or jump (legal range 1–3).

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `id_rs1`, `id_rs2` input 5 each: source register indices of the instruction in IF/ID.
- `id_uses_rs1`, `id_uses_rs2` input 1 each: the instruction in IF/ID actually reads that source.
- `ex_rd` input 5: destination register of the instruction in ID/EX.
- `ex_memread` input 1: the ID/EX instruction is a load (`MemRW == 2'b10`).
- `wb_rd` input 5: destination register of the instruction being written back.
- `wb_regwrite` input 1: write-back enable.
- `br_taken` input 1: a branch or jump resolved taken this cycle.
- `dmem_req` input 1: the MEM stage has an outstanding data access.
- `dmem_ready` input 1: the data memory completes the access this cycle.
- `pc_keep` output 1: hold the PC.
- `if_keep` output 1: hold IF/ID.
- `if_flush` output 1: load IF/ID with a NOP.
- `id_keep` output 1: drives decode `keep`.
- `id_nop` output 1: drives decode `nop`.
- `id_ex_write` output 2: [1] bypasses `rs1`, [0] bypasses `rs2`.
- `stall_cycles` output 32: performance counter.
- `flush_events` output 16: performance counter.

## Operation
- **States:**
  - `RUN`: normal flow.
  - `FLUSH`: down-counter `fcnt` holds the remaining bubbles.
  - `MEM_WAIT`: pipeline frozen.
- **Load-use detection (combinational):** `lu` = `ex_memread` && `ex_rd` != 0 && ((`id_uses_rs1` && `ex_rd` == `id_rs1`) || (`id_uses_rs2` && `ex_rd` == `id_rs2`)).
- **Bypass:** `id_ex_write[1]` = `wb_regwrite` && `wb_rd` != 0 && `wb_rd` == `id_rs1`; bit [0] is the same with `id_rs2`. It is evaluated in every state, including `MEM_WAIT`, so the held ID/EX operands pick up a write-back that lands during the freeze.
- **`RUN` actions, in priority order:**
  1. `dmem_req` && !`dmem_ready`: assert `pc_keep`, `if_keep`, `id_keep`; go to `MEM_WAIT`.
  2. `br_taken`: assert `if_flush` and `id_nop`; set `fcnt` = `FLUSH_DEPTH`-1; go to `FLUSH` if `fcnt` > 0, otherwise stay in `RUN`.
  3. `lu`: assert `pc_keep`, `if_keep`, `id_nop` for this cycle only. There is no state change; the condition clears once the bubble has entered EX.
  4. Otherwise all outputs are 0.
- **`FLUSH`:**
  - Each cycle: assert `if_flush` and `id_nop`, then decrement `fcnt`; go to `RUN` when `fcnt` reaches 0.
  - A memory wait arriving in `FLUSH` takes priority: freeze, and keep `fcnt`.
- **`MEM_WAIT`:**
  - While `dmem_ready` = 0: assert `pc_keep`, `if_keep`, `id_keep`; `id_nop` = 0.
  - On `dmem_ready` = 1: drop the keeps that same cycle and resume at the saved return state.
- **Simultaneous events:**
  - A `br_taken` during `MEM_WAIT` is latched in `br_pend` and processed as a `RUN` branch in the first cycle after ready.
  - `lu` during a flush is ignored; the instruction is being flushed anyway.
- `id_nop` and `id_keep` are never asserted together.
- **Reset (including mid-operation):**
  - State goes to `RUN`; `fcnt`, `br_pend` and return state are cleared.
  - All control outputs are 0 while `rst` = 0.
  - Counters reset to 0.

## Timing
- All control outputs are Mealy and combinational from the state register plus the same-cycle inputs. They take effect at the next rising `clk` in the stage registers.
- Load-use costs exactly 1 bubble.
- A taken branch costs exactly `FLUSH_DEPTH` bubble cycles, starting in the cycle `br_taken` is high.
- A memory wait of N cycles with `dmem_ready` low freezes the pipeline for exactly N cycles.
- State and counter updates happen on rising `clk`.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments in every cycle where `pc_keep` = 1.
  - `flush_events` increments once per accepted branch flush.
  - Both counters saturate at their maximum value.
- `HAZARD_PERF_CNT_EN` undefined: the ports remain and are tied to 0, and no counter flops are built.

## Test plan
- **Load-use:** load `x5` in EX, `add x6,x5,x1` in ID → one cycle with `pc_keep`=`if_keep`=`id_nop`=1, then all 0 the next cycle. Repeat with `ex_rd`=0 → no stall.
- **Branch flush:** `br_taken` pulse, `FLUSH_DEPTH`=2 → `if_flush`/`id_nop` high for exactly 2 cycles; `flush_events`=1 with the macro defined.
- **Memory wait:** `dmem_req`=1, `dmem_ready` low for 3 cycles → `pc_keep`/`if_keep`/`id_keep` high for 3 cycles; `stall_cycles`=3.
- **Branch during wait:** `br_taken` during `MEM_WAIT` → flush starts in the first cycle after `dmem_ready`; 2 bubbles.
- **Bypass:** `wb_rd`=7, `wb_regwrite`=1, `id_rs1`=`id_rs2`=7 → `id_ex_write`=2'b11. With `wb_rd`=0 → 2'b00.
- **Reset:** `rst` low mid-`FLUSH` with `fcnt`=1 → all outputs 0 immediately. After release, state is `RUN` and no residual bubble is inserted.
